// File: rtl/mult_job_sequencer.sv
// Job sequencer for the taint-tracked sequential multiplier.
// Buffers operand pairs, issues one job at a time, captures and presents results.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/_t, in_ready           operand handshake (ready = !full)
//   in_multiplier/_t                operand A and its taint
//   in_multiplicand/_t              operand B and its taint
//   mult_start/_t                   one-cycle start pulse to multiplier
//   mult_multiplier/_t              operand A held towards multiplier
//   mult_multiplicand/_t            operand B held towards multiplier
//   mult_product/_t, mult_done/_t   multiplier result and level done
//   out_valid/_t, out_ready         result handshake
//   out_product/_t                  captured product and its taint
//   timeout_err                     sticky; a job was abandoned
module mult_job_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_valid_t,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_multiplier,
  input  logic [WIDTH-1:0]   in_multiplier_t,
  input  logic [WIDTH-1:0]   in_multiplicand,
  input  logic [WIDTH-1:0]   in_multiplicand_t,
  output logic               mult_start,
  output logic               mult_start_t,
  output logic [WIDTH-1:0]   mult_multiplier,
  output logic [WIDTH-1:0]   mult_multiplier_t,
  output logic [WIDTH-1:0]   mult_multiplicand,
  output logic [WIDTH-1:0]   mult_multiplicand_t,
  input  logic [2*WIDTH-1:0] mult_product,
  input  logic [2*WIDTH-1:0] mult_product_t,
  input  logic               mult_done,
  input  logic               mult_done_t,
  output logic               out_valid,
  output logic               out_valid_t,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [2*WIDTH-1:0] out_product_t,
  output logic               timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q  [DEPTH];
  logic [WIDTH-1:0] at_q [DEPTH];
  logic [WIDTH-1:0] b_q  [DEPTH];
  logic [WIDTH-1:0] bt_q [DEPTH];
  logic             vt_q [DEPTH];

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] wd_q, wd_d;
  logic [PW-1:0] prod_q, prod_d;
  logic [PW-1:0] prodt_q, prodt_d;
  logic          ovt_q, ovt_d;
  logic          err_q, err_d;

  logic push, pop, cap, tmo;
  logic busy;

  // No bypass: a pop in the same cycle does not open the input.
  assign in_ready = (cnt_q != CW'(DEPTH));
  assign push     = in_valid & in_ready;

  // Storage needs no reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      a_q[wr_q]  <= in_multiplier;
      at_q[wr_q] <= in_multiplier_t;
      b_q[wr_q]  <= in_multiplicand;
      bt_q[wr_q] <= in_multiplicand_t;
      vt_q[wr_q] <= in_valid_t;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      prod_q  <= '0;
      prodt_q <= '0;
      ovt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      prod_q  <= prod_d;
      prodt_q <= prodt_d;
      ovt_q   <= ovt_d;
      err_q   <= err_d;
    end
  end

  // Next state. Done is checked before the watchdog so it wins a tie.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cap     = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE:  if (cnt_q != '0) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mult_done) begin
          cap     = 1'b1;
          pop     = 1'b1;
          state_d = HOLD;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          tmo     = 1'b1;
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    wd_d    = wd_q;
    if (state_q == ISSUE)     wd_d = '0;
    else if (state_q == WAIT) wd_d = wd_q + TW'(1);
    prod_d  = cap ? mult_product : prod_q;
    prodt_d = cap ? mult_product_t : prodt_q;
    ovt_d   = cap ? (mult_done_t | vt_q[rd_q]) : ovt_q;
    err_d   = err_q | tmo;
  end

  // Outputs.
  assign busy = (state_q == ISSUE) || (state_q == WAIT);

  always_comb begin
    mult_start          = (state_q == ISSUE);
    mult_start_t        = (state_q == ISSUE) ? vt_q[rd_q] : 1'b0;
    mult_multiplier     = busy ? a_q[rd_q]  : '0;
    mult_multiplier_t   = busy ? at_q[rd_q] : '0;
    mult_multiplicand   = busy ? b_q[rd_q]  : '0;
    mult_multiplicand_t = busy ? bt_q[rd_q] : '0;
    out_valid           = (state_q == HOLD);
    out_valid_t         = ovt_q;
    out_product         = prod_q;
    out_product_t       = prodt_q;
    timeout_err         = err_q;
  end

endmodule

// File: doc/mult_job_sequencer.md
Name: mult_job_sequencer

Overview:
Upstream/downstream job sequencer for the taint-tracked sequential multiplier. It accepts operand pairs through a valid/ready interface and buffers them in a small FIFO. It issues one job at a time to the multiplier (start pulse plus held operands), captures the product on done, and presents the result through a valid/ready output. Every data and control signal carries a shadow taint signal (_t suffix), and taint propagates with the data.

Parameters:
WIDTH, 4, operand width; product width is 2*WIDTH
DEPTH, 2, operand FIFO entries; power of 2, >= 2
TIMEOUT, 24, maximum WAIT cycles before a job is abandoned

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair offered
in_valid_t  input  1  taint of in_valid
in_ready  output  1  FIFO can accept; equals !full
in_multiplier  input  WIDTH  operand A
in_multiplier_t  input  WIDTH  taint of operand A
in_multiplicand  input  WIDTH  operand B
in_multiplicand_t  input  WIDTH  taint of operand B
mult_start  output  1  one-cycle start pulse to multiplier
mult_start_t  output  1  taint of mult_start
mult_multiplier  output  WIDTH  operand A to multiplier
mult_multiplier_t  output  WIDTH  its taint
mult_multiplicand  output  WIDTH  operand B to multiplier
mult_multiplicand_t  output  WIDTH  its taint
mult_product  input  2*WIDTH  multiplier product
mult_product_t  input  2*WIDTH  its taint
mult_done  input  1  multiplier productDone (level)
mult_done_t  input  1  its taint
out_valid  output  1  result available
out_valid_t  output  1  taint of out_valid
out_ready  input  1  consumer accepts result
out_product  output  2*WIDTH  captured product
out_product_t  output  2*WIDTH  captured product taint
timeout_err  output  1  sticky; a job was abandoned

Behaviour:
- Reset: one clock edge with rst=1 returns the block to its reset state:
  - FIFO empty; state IDLE; in_ready=1.
  - mult_start=0; mult_* operands and all _t outputs are 0.
  - out_valid=0; out_product=0; timeout_err=0.
  - Reset mid-job drops the in-flight job and all buffered jobs.
- FIFO push when in_valid & in_ready. Each entry stores A, A_t, B, B_t and in_valid_t.
- Full FIFO: in_ready=0, with no same-cycle bypass even if a pop occurs.
- Pointers wrap modulo DEPTH. The count distinguishes full from empty.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - FIFO non-empty -> ISSUE next cycle.
  - mult operands driven 0.
- ISSUE (exactly 1 cycle):
  - mult_start=1.
  - mult_start_t = head in_valid_t.
  - Head operands and their taint drive mult_*.
  - -> WAIT.
- WAIT:
  - Head operands held stable on mult_*; mult_start=0.
  - The watchdog counter increments from 0 each cycle.
  - mult_done=1: capture out_product <= mult_product and out_product_t <= mult_product_t. Set out_valid_t <= mult_done_t | head in_valid_t. Pop the FIFO, then -> HOLD.
  - Counter reaches TIMEOUT-1 with no done: pop (drop job), set timeout_err=1, -> IDLE. timeout_err clears only on rst.
  - Done and timeout in the same cycle: done wins.
- HOLD:
  - out_valid=1; out_product is stable until handshake.
  - out_valid & out_ready: -> IDLE, out_valid=0 next cycle.
  - out_product keeps its last value after handshake.
- Minimum latency from push into an empty FIFO to out_valid:
  - IDLE decision 1 cycle + ISSUE 1 cycle + multiplier latency + 1 capture cycle.
- The multiplier deasserts mult_done on receiving start. mult_done is not sampled during ISSUE.
- Pushes continue during ISSUE/WAIT/HOLD up to DEPTH entries.
- Jobs complete strictly in FIFO order.

Test Plan:
- Single job: push A=3, B=5, no taint, out_ready=1.
  -> One mult_start pulse, then out_valid with out_product=15 and out_product_t=0. in_ready stays 1.
- Back-pressure: push 3 jobs (2x7, 4x4, 15x15) with out_ready=0.
  -> in_ready=0 after the 2nd push while the first job is still held. Releasing out_ready yields 14, 16, 225 in order.
- Taint: push A=6, A_t=4'b0001, B=2, with the multiplier model returning product_t=8'h03.
  -> mult_multiplier_t=0001 during ISSUE/WAIT; out_product=12; out_product_t=8'h03.
  -> in_valid_t=1 on the push gives mult_start_t=1 and out_valid_t=1.
- Timeout: mult_done held 0 after start.
  -> After 24 WAIT cycles, timeout_err=1 and the FIFO count drops by 1. The next queued job then issues normally.
- Reset mid-WAIT with 2 queued jobs: assert rst for 1 cycle.
  -> Next cycle: in_ready=1, out_valid=0, mult_start=0, timeout_err=0. No result is produced for the dropped jobs.
- Done/timeout collision: mult_done rises exactly on the TIMEOUT-1 cycle.
  -> Product captured, out_valid=1, timeout_err stays 0.
